// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target that maps bus transfers onto a simple
// register pointer interface (reg_addr / reg_wdata / reg_we / reg_re / reg_rdata).
// Optional SCL/SDA glitch filter: define I2C_TARGET_FILTER_EN.
`timescale 1ns/1ps
module i2c_target_regs #(
  parameter logic [6:0] ADDRESS    = 7'h50,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_o,
  output logic       sda_t,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  state_t     state;
  logic       scl_s1, scl_s2, sda_s1, sda_s2;
  logic       scl_f, sda_f;
  logic       scl_q, sda_q;
  logic       lines_ok;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] tx_reg;
  logic       rw;

  assign sda_o = 1'b0;

  // A filter length below one would never accept a level change
  if (FILTER_LEN < 1) begin : g_bad_filter_len
    $error("FILTER_LEN must be at least 1");
  end

  // Two-flop synchronizers for the asynchronous bus lines, idle-high at reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_TARGET_FILTER_EN
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic [CW-1:0] scl_cnt, sda_cnt;

  // Accept a new line level only after FILTER_LEN consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_f   <= 1'b1;
      sda_f   <= 1'b1;
      scl_cnt <= '0;
      sda_cnt <= '0;
    end else begin
      if (scl_s2 == scl_f) begin
        scl_cnt <= '0;
      end else if (scl_cnt == CW'(FILTER_LEN - 1)) begin
        scl_f   <= scl_s2;
        scl_cnt <= '0;
      end else begin
        scl_cnt <= scl_cnt + CW'(1);
      end
      if (sda_s2 == sda_f) begin
        sda_cnt <= '0;
      end else if (sda_cnt == CW'(FILTER_LEN - 1)) begin
        sda_f   <= sda_s2;
        sda_cnt <= '0;
      end else begin
        sda_cnt <= sda_cnt + CW'(1);
      end
    end
  end
`else
  assign scl_f = scl_s2;
  assign sda_f = sda_s2;
`endif

  // Previous line levels for edge detection; lines_ok blocks the bogus edges
  // seen while the pipeline refills after reset, so only a fresh START counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q    <= 1'b1;
      sda_q    <= 1'b1;
      lines_ok <= 1'b0;
    end else begin
      scl_q <= scl_f;
      sda_q <= sda_f;
      if (scl_s1 == scl_s2 && sda_s1 == sda_s2 && scl_f == scl_s2 &&
          sda_f == sda_s2 && scl_q == scl_f && sda_q == sda_f)
        lines_ok <= 1'b1;
    end
  end

  assign scl_rise  = lines_ok &  scl_f & ~scl_q;
  assign scl_fall  = lines_ok & ~scl_f &  scl_q;
  assign start_det = lines_ok &  scl_f &  scl_q &  sda_q & ~sda_f;
  assign stop_det  = lines_ok &  scl_f &  scl_q & ~sda_q &  sda_f;

  // Protocol engine: byte framing, ACK/data driving on SDA and register strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sda_t     <= 1'b1;
      reg_we    <= 1'b0;
      reg_re    <= 1'b0;
      busy      <= 1'b0;
      reg_addr  <= 8'h00;
      reg_wdata <= 8'h00;
      bit_cnt   <= 4'd0;
      shift_reg <= 8'h00;
      tx_reg    <= 8'h00;
      rw        <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      if (reg_we)
        reg_addr <= reg_addr + 8'd1;
      if (reg_re) begin
        tx_reg <= {reg_rdata[6:0], 1'b0};
        sda_t  <= reg_rdata[7];
      end
      case (state)
        IDLE: begin
        end
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_reg <= {shift_reg[6:0], sda_f};
            bit_cnt   <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (state == ADDR) begin
              if (shift_reg[7:1] == ADDRESS) begin
                rw    <= shift_reg[0];
                busy  <= 1'b1;
                sda_t <= 1'b0;
                state <= ADDR_ACK;
              end else begin
                sda_t <= 1'b1;
                state <= IGNORE;
              end
            end else if (state == PTR) begin
              reg_addr <= shift_reg;
              sda_t    <= 1'b0;
              state    <= PTR_ACK;
            end else begin
              reg_wdata <= shift_reg;
              reg_we    <= 1'b1;
              sda_t     <= 1'b0;
              state     <= WDATA_ACK;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 4'd0;
            sda_t   <= 1'b1;
            if (rw) begin
              reg_re <= 1'b1;
              state  <= RDATA;
            end else begin
              state <= PTR;
            end
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 4'd0;
            sda_t   <= 1'b1;
            state   <= WDATA;
          end
        end
        RDATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt <= 4'd0;
              sda_t   <= 1'b1;
              state   <= RDATA_ACK;
            end else if (bit_cnt != 4'd0) begin
              sda_t  <= tx_reg[7];
              tx_reg <= {tx_reg[6:0], 1'b0};
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            reg_addr <= reg_addr + 8'd1;
            if (sda_f)
              state <= IGNORE;
            else
              bit_cnt <= 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt <= 4'd0;
            reg_re  <= 1'b1;
            state   <= RDATA;
          end
        end
        IGNORE: begin
          sda_t <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (start_det) begin
        state   <= ADDR;
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
      end
      if (stop_det) begin
        state   <= IDLE;
        bit_cnt <= 4'd0;
        sda_t   <= 1'b1;
        busy    <= 1'b0;
      end
    end
  end

endmodule
